// File: rtl/spi_device_responder.sv
// spi_device_responder: mode-0 MSB-first SPI target, oversampled in clk_sys_i, with RX valid/ready and a one-entry TX holding register
module spi_device_responder #(
    parameter logic [7:0] TxIdleByte = 8'hFF
) (
    input  logic       clk_sys_i,
    input  logic       rst_sys_i,
    input  logic       spi_sck_i,
    input  logic       spi_cs_ni,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_en_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       rx_overflow_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_underrun_o
);
    logic [2:0] sck_q, cs_q;
    logic [1:0] mosi_q;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift, rx_byte, tx_shift, tx_next, hold_data;
    logic       sck_rise, sck_fall, cs_low, cs_fall;
    logic       rx_done, rx_load, tx_load, tx_shift_en, tx_accept;

    always_comb begin
        sck_rise    = sck_q[1] & ~sck_q[2];
        sck_fall    = ~sck_q[1] & sck_q[2];
        cs_low      = ~cs_q[1];
        cs_fall     = cs_low & cs_q[2];
        rx_byte     = {rx_shift[6:0], mosi_q[1]};
        rx_done     = cs_low & sck_rise & (bit_cnt == 3'd7);
        rx_load     = rx_done & (~rx_valid_o | rx_ready_i);
        tx_load     = cs_fall | (cs_low & sck_fall & (bit_cnt == 3'd0));
        tx_shift_en = cs_low & sck_fall & (bit_cnt != 3'd0);
        tx_accept   = tx_valid_i & tx_ready_o;
        // tx_ready_o doubles as the holding-register-empty flag
        tx_next     = tx_load ? (tx_ready_o ? TxIdleByte : hold_data) :
                      tx_shift_en ? {tx_shift[6:0], 1'b0} : tx_shift;
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            sck_q         <= 3'b000;
            cs_q          <= 3'b111;
            mosi_q        <= 2'b00;
            bit_cnt       <= 3'd0;
            rx_shift      <= 8'h00;
            tx_shift      <= 8'h00;
            hold_data     <= 8'h00;
            spi_miso_o    <= 1'b0;
            spi_miso_en_o <= 1'b0;
            rx_data_o     <= 8'h00;
            rx_valid_o    <= 1'b0;
            rx_overflow_o <= 1'b0;
            tx_ready_o    <= 1'b1;
            tx_underrun_o <= 1'b0;
        end else begin
            sck_q         <= {sck_q[1:0], spi_sck_i};
            cs_q          <= {cs_q[1:0], spi_cs_ni};
            mosi_q        <= {mosi_q[0], spi_mosi_i};
            // CS high discards any partial byte and aborts framing
            bit_cnt       <= cs_low ? bit_cnt + {2'b00, sck_rise} : 3'd0;
            rx_shift      <= !cs_low ? 8'h00 : sck_rise ? rx_byte : rx_shift;
            tx_shift      <= tx_next;
            spi_miso_o    <= cs_low & tx_next[7];
            spi_miso_en_o <= cs_low;
            rx_data_o     <= rx_load ? rx_byte : rx_data_o;
            rx_valid_o    <= rx_done | (rx_valid_o & ~rx_ready_i);
            rx_overflow_o <= rx_done & rx_valid_o & ~rx_ready_i;
            hold_data     <= tx_accept ? tx_data_i : hold_data;
            tx_ready_o    <= tx_accept ? 1'b0 : (tx_load | tx_ready_o);
            tx_underrun_o <= tx_load & tx_ready_o;
        end
    end
endmodule

// File: tb/tb_spi_device_responder.sv
// tb_spi_device_responder: directed SPI host stimulus with a cycle-level reference model and literal end-of-test checks
module tb_spi_device_responder;
    localparam int H = 8;

    logic       clk = 0, rst = 1, sck = 0, cs_n = 1, mosi = 0, rx_ready = 1, tx_valid = 0;
    logic [7:0] tx_data = 8'h00;
    logic       spi_miso_o, spi_miso_en_o, rx_valid_o, rx_overflow_o, tx_ready_o, tx_underrun_o;
    logic [7:0] rx_data_o;

    spi_device_responder dut (
        .clk_sys_i(clk), .rst_sys_i(rst), .spi_sck_i(sck), .spi_cs_ni(cs_n), .spi_mosi_i(mosi),
        .spi_miso_o(spi_miso_o), .spi_miso_en_o(spi_miso_en_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready), .rx_overflow_o(rx_overflow_o),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o), .tx_underrun_o(tx_underrun_o)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int und_cnt = 0, ovf_cnt = 0, rxv_cnt = 0, rx_n = 0;
    logic [7:0] rx_log [0:63];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pin history stands in for the synchronisers; the
    // transmit byte is tracked as a byte plus a bit index, the holding
    // register as a queue of at most one entry.
    bit         started = 0;
    bit         s1, s2, s3, c1, c2, c3, m1, m2;
    int         m_bits, m_rx, m_idx;
    logic [7:0] m_tx;
    logic [7:0] hold_q [$];
    logic       e_miso, e_en, e_rxv, e_ovf, e_rdy, e_und;
    logic [7:0] e_rxd;

    always @(posedge clk) begin : model
        bit sr, sf, lo, cf, done, load, shf, acc;
        if (rst) begin
            started = 1;
            m_bits = 0; m_rx = 0; m_idx = 7; m_tx = 8'h00;
            hold_q.delete();
            e_miso = 0; e_en = 0; e_rxv = 0; e_rxd = 8'h00; e_ovf = 0; e_rdy = 1; e_und = 0;
            s1 = 0; s2 = 0; s3 = 0; c1 = 1; c2 = 1; c3 = 1; m1 = 0; m2 = 0;
        end else begin
            sr = s2 && !s3; sf = !s2 && s3; lo = !c2; cf = lo && c3;
            e_ovf = 0; e_und = 0; done = 0;
            load = cf || (lo && sf && m_bits == 0);
            shf  = lo && sf && m_bits != 0;
            acc  = tx_valid && hold_q.size() == 0;
            if (!lo) begin
                m_bits = 0; m_rx = 0;
            end else if (sr) begin
                m_rx = (m_rx * 2 + int'(m2)) % 256;
                done = (m_bits == 7);
                m_bits = (m_bits + 1) % 8;
            end
            if (done && (!e_rxv || rx_ready)) begin
                e_rxd = m_rx[7:0]; e_rxv = 1;
            end else if (done) e_ovf = 1;
            else if (rx_ready) e_rxv = 0;
            if (load) begin
                if (hold_q.size() > 0) m_tx = hold_q.pop_front();
                else begin m_tx = 8'hFF; e_und = 1; end
                m_idx = 7;
            end else if (shf && m_idx > 0) m_idx--;
            if (acc) hold_q.push_back(tx_data);
            e_rdy = hold_q.size() == 0;
            e_en = lo;
            e_miso = lo ? m_tx[m_idx] : 1'b0;
            s3 = s2; s2 = s1; s1 = sck;
            c3 = c2; c2 = c1; c1 = cs_n;
            m2 = m1; m1 = mosi;
        end
    end

    always @(negedge clk) if (started) begin
        chk("miso", spi_miso_o, e_miso);
        chk("miso_en", spi_miso_en_o, e_en);
        chk("rx_valid", rx_valid_o, e_rxv);
        chk("rx_data", rx_data_o, e_rxd);
        chk("rx_overflow", rx_overflow_o, e_ovf);
        chk("tx_ready", tx_ready_o, e_rdy);
        chk("tx_underrun", tx_underrun_o, e_und);
        und_cnt += int'(tx_underrun_o);
        ovf_cnt += int'(rx_overflow_o);
        rxv_cnt += int'(rx_valid_o);
        if (rx_valid_o && rx_ready && rx_n < 64) begin
            rx_log[rx_n] = rx_data_o;
            rx_n++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic do_reset();
        rst = 1; sck = 0; cs_n = 1; mosi = 0; tx_valid = 0; rx_ready = 1;
        tick(2);
        rst = 0;
        tick(3);
    endtask

    task automatic tx_push(input logic [7:0] b);
        int w = 0;
        while (!tx_ready_o && w < 50) begin tick(); w++; end
        chk("tx_push_wait", w < 50, 1);
        tx_data = b; tx_valid = 1;
        tick();
        tx_valid = 0;
    endtask

    task automatic xfer(input logic [7:0] mo, input int nb, input bit end_cs, input bit ready_last,
                        output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nb; i++) begin
            mosi = mo[7-i];
            tick(H);
            mi = {mi[6:0], spi_miso_o};
            sck = 1;
            if (ready_last && i == nb - 1) begin tick(2); rx_ready = 1; tick(H - 2); end
            else tick(H);
            sck = 0;
            if (end_cs && i == nb - 1) cs_n = 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] mi;
        int u0, o0, r0, v0;
        do_reset();
        chk("reset_tx_ready", tx_ready_o, 1);
        chk("reset_rx_valid", rx_valid_o, 0);
        chk("reset_miso_en", spi_miso_en_o, 0);

        // single byte
        tx_push(8'hA5);
        u0 = und_cnt; r0 = rx_n; v0 = rxv_cnt;
        cs_n = 0; tick(H);
        xfer(8'h3C, 8, 1, 0, mi);
        tick(2 * H);
        chk("t1_host_rx", mi, 8'hA5);
        chk("t1_rx_count", rx_n - r0, 1);
        chk("t1_rx_byte", rx_log[r0], 8'h3C);
        chk("t1_valid_cycles", rxv_cnt - v0, 1);
        chk("t1_underruns", und_cnt - u0, 0);

        // back-to-back with underrun
        do_reset();
        tx_push(8'h55);
        u0 = und_cnt; r0 = rx_n;
        cs_n = 0; tick(H);
        xfer(8'h01, 8, 0, 0, mi);
        chk("t2_host_rx0", mi, 8'h55);
        xfer(8'h02, 8, 1, 0, mi);
        chk("t2_host_rx1", mi, 8'hFF);
        tick(2 * H);
        chk("t2_underruns", und_cnt - u0, 1);
        chk("t2_rx_count", rx_n - r0, 2);
        chk("t2_rx_byte0", rx_log[r0], 8'h01);
        chk("t2_rx_byte1", rx_log[r0+1], 8'h02);

        // RX overflow then simultaneous accept and load
        do_reset();
        rx_ready = 0;
        o0 = ovf_cnt; r0 = rx_n;
        cs_n = 0; tick(H);
        xfer(8'h11, 8, 0, 0, mi);
        xfer(8'h22, 8, 0, 0, mi);
        tick(4);
        chk("t3_held_valid", rx_valid_o, 1);
        chk("t3_held_data", rx_data_o, 8'h11);
        chk("t3_overflows", ovf_cnt - o0, 1);
        xfer(8'h33, 8, 1, 1, mi);
        tick(2 * H);
        chk("t3_overflows_after", ovf_cnt - o0, 1);
        chk("t3_rx_count", rx_n - r0, 2);
        chk("t3_rx_byte0", rx_log[r0], 8'h11);
        chk("t3_rx_byte1", rx_log[r0+1], 8'h33);

        // mid-byte abort
        do_reset();
        r0 = rx_n; v0 = rxv_cnt;
        cs_n = 0; tick(H);
        xfer(8'hAB, 5, 1, 0, mi);
        tick(2 * H);
        chk("t4_abort_valid_cycles", rxv_cnt - v0, 0);
        cs_n = 0; tick(H);
        xfer(8'h7E, 8, 1, 0, mi);
        tick(2 * H);
        chk("t4_rx_count", rx_n - r0, 1);
        chk("t4_rx_byte", rx_log[r0], 8'h7E);

        // load and offer on the same cycle
        do_reset();
        tx_push(8'hC3);
        u0 = und_cnt;
        cs_n = 0;
        tick(2);
        tx_data = 8'h96; tx_valid = 1;
        tick(3);
        tx_valid = 0;
        chk("t5_hold_full", tx_ready_o, 0);
        tick(H - 5);
        xfer(8'h5A, 8, 0, 0, mi);
        chk("t5_host_rx0", mi, 8'hC3);
        xfer(8'hA5, 8, 1, 0, mi);
        chk("t5_host_rx1", mi, 8'h96);
        tick(2 * H);
        chk("t5_underruns", und_cnt - u0, 0);

        // reset mid-transfer
        do_reset();
        tx_push(8'h5A);
        cs_n = 0; tick(H);
        xfer(8'hC9, 3, 0, 0, mi);
        rst = 1; cs_n = 1; sck = 0;
        tick();
        chk("t6_miso", spi_miso_o, 0);
        chk("t6_miso_en", spi_miso_en_o, 0);
        chk("t6_rx_valid", rx_valid_o, 0);
        chk("t6_rx_data", rx_data_o, 8'h00);
        chk("t6_tx_ready", tx_ready_o, 1);
        chk("t6_flags", {rx_overflow_o, tx_underrun_o}, 2'b00);
        rst = 0;
        tick(3);
        r0 = rx_n;
        tx_push(8'h5A);
        cs_n = 0; tick(H);
        xfer(8'hC9, 8, 1, 0, mi);
        tick(2 * H);
        chk("t6_host_rx", mi, 8'h5A);
        chk("t6_rx_count", rx_n - r0, 1);
        chk("t6_rx_byte", rx_log[r0], 8'hC9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
